// File: rtl/frv_masked_pkg.sv
// frv_masked_pkg: op encoding and geometry helpers for the masked shift/rotate pipeline
package frv_masked_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ROR = 2'b10,
        OP_ROL = 2'b11
    } op_t;

    function automatic int shw(input int xlen);
        return $clog2(xlen);
    endfunction

    // Start of the fill slice for share j at level k inside the rng bus
    function automatic int fill_off(input int j, input int k, input int xlen);
        return j * (xlen - 1) + (1 << k) - 1;
    endfunction

endpackage

// File: rtl/frv_masked_shfrot_stage.sv
// frv_masked_shfrot_stage: one combinational 2^LEVEL shift/rotate level applied to every share
module frv_masked_shfrot_stage
    import frv_masked_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NSHARES = 2,
    parameter int LEVEL   = 0
) (
    input  logic [NSHARES*XLEN-1:0]           in_shares,
    input  logic [1:0]                        op,
    input  logic                              en,
    input  logic [(NSHARES-1)*(2**LEVEL)-1:0] rng,
    output logic [NSHARES*XLEN-1:0]           out_shares
);
    localparam int D = 2 ** LEVEL;

    logic [D-1:0] fill_x;

    // The last share's fill cancels the others so the recombined fill is zero
    always_comb begin
        fill_x = '0;
        for (int i = 0; i < NSHARES - 1; i++) fill_x ^= rng[i*D +: D];
    end

    for (genvar j = 0; j < NSHARES; j++) begin : g_sh
        logic [XLEN-1:0] s;
        logic [D-1:0]    f;
        if (j == NSHARES - 1) begin : g_last
            assign f = fill_x;
        end else begin : g_rnd
            assign f = rng[j*D +: D];
        end
        assign s = in_shares[j*XLEN +: XLEN];
        assign out_shares[j*XLEN +: XLEN] =
            !en            ? s :
            op == OP_SLL   ? {s[XLEN-D-1:0], f} :
            op == OP_SRL   ? {f, s[XLEN-1:D]} :
            op == OP_ROR   ? {s[D-1:0], s[XLEN-1:D]} :
                             {s[XLEN-D-1:0], s[XLEN-1:XLEN-D]};
    end

endmodule

// File: rtl/frv_masked_shfrot_pipe.sv
// frv_masked_shfrot_pipe: log2(XLEN)-stage pipelined masked shifter/rotator with global stall and flush
module frv_masked_shfrot_pipe
    import frv_masked_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int NSHARES = 2,
    localparam int SHW     = shw(XLEN)
) (
    input  logic                             g_clk,
    input  logic                             g_resetn,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NSHARES*XLEN-1:0]          in_shares,
    input  logic [SHW-1:0]                   in_shamt,
    input  logic [1:0]                       in_op,
    input  logic [(NSHARES-1)*(XLEN-1)-1:0]  rng,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NSHARES*XLEN-1:0]          out_shares,
    output logic                             idle
);
    localparam int L = SHW;

    logic                    en;
    logic [L-1:0]            v_q;
    logic [NSHARES*XLEN-1:0] s_src [L];
    logic [NSHARES*XLEN-1:0] s_d   [L];
    logic [NSHARES*XLEN-1:0] sh_q  [L];
    logic [1:0]              o_src [L];
    logic [1:0]              op_q  [L-1];
    logic [SHW-1:0]          a_src [L];
    logic [SHW-1:0]          amt_q [L-1];

    assign en         = !out_valid || out_ready;
    assign in_ready   = en && !flush;
    assign out_valid  = v_q[L-1];
    assign out_shares = sh_q[L-1];
    assign idle       = ~|v_q;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        logic [(NSHARES-1)*(2**k)-1:0] r;
        for (genvar j = 0; j < NSHARES - 1; j++) begin : g_r
            assign r[j*(2**k) +: 2**k] = rng[fill_off(j, k, XLEN) +: 2**k];
        end
        if (k == 0) begin : g_head
            assign s_src[k] = in_shares;
            assign o_src[k] = in_op;
            assign a_src[k] = in_shamt;
        end else begin : g_body
            assign s_src[k] = sh_q[k-1];
            assign o_src[k] = op_q[k-1];
            assign a_src[k] = amt_q[k-1];
        end
        frv_masked_shfrot_stage #(
            .XLEN    (XLEN),
            .NSHARES (NSHARES),
            .LEVEL   (k)
        ) u_stage (
            .in_shares  (s_src[k]),
            .op         (o_src[k]),
            .en         (a_src[k][0]),
            .rng        (r),
            .out_shares (s_d[k])
        );
    end

    // Each register keeps the not-yet-consumed shamt bits right-aligned
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            v_q <= '0;
            for (int i = 0; i < L; i++) sh_q[i] <= '0;
            for (int i = 0; i < L - 1; i++) begin
                op_q[i]  <= '0;
                amt_q[i] <= '0;
            end
        end else begin
            if (flush) v_q <= '0;
            else if (en) v_q <= {v_q[L-2:0], in_valid};
            if (en) begin
                for (int i = 0; i < L; i++) sh_q[i] <= s_d[i];
                for (int i = 0; i < L - 1; i++) begin
                    op_q[i]  <= o_src[i];
                    amt_q[i] <= a_src[i] >> 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frv_masked_shfrot_pipe.sv
// tb_frv_masked_shfrot_pipe: randomized scoreboard bench against a recombined-value reference model
module tb_frv_masked_shfrot_pipe;
    localparam int XLEN = 32, NSHARES = 2, SHW = 5, RW = (NSHARES - 1) * (XLEN - 1);

    logic g_clk = 0, g_resetn = 1, flush = 0, in_valid = 0, out_ready = 1;
    logic in_ready, out_valid, idle;
    logic [63:0] in_shares = '0, out_shares;
    logic [SHW-1:0] in_shamt = '0;
    logic [1:0] in_op = '0;
    logic [RW-1:0] rng = '0;

    frv_masked_shfrot_pipe #(.XLEN(XLEN), .NSHARES(NSHARES)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_shares(in_shares),
        .in_shamt(in_shamt), .in_op(in_op), .rng(rng),
        .out_valid(out_valid), .out_ready(out_ready), .out_shares(out_shares),
        .idle(idle)
    );

    always #5 g_clk = ~g_clk;

    int cyc = 0;
    always @(posedge g_clk) cyc <= cyc + 1;

    int errors = 0, checks = 0;
    int st_lo = 0, st_hi = 0;
    bit rnd_rdy = 0;

    typedef struct {
        logic [31:0] rec;
        bit          exact;
        logic [63:0] sh;
        bit          b0chk;
        logic        b0;
        bit          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];
    exp_t me;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [31:0] x, input int s, input logic [1:0] op);
        logic [63:0] d;
        d = {x, x};
        if (op == 2'd0) return x << s;
        if (op == 2'd1) return x >> s;
        if (op == 2'd2) begin
            d = d >> s;
            return d[31:0];
        end
        d = d << s;
        return d[63:32];
    endfunction

    task automatic set_rdy();
        out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : !(cyc >= st_lo && cyc < st_hi);
    endtask

    task automatic issue(input logic [31:0] x, input logic [4:0] s, input logic [1:0] op,
                         input bit exact, input bit b0chk, input bit lat);
        logic [31:0] m;
        exp_t e;
        m = $urandom;
        for (int t = 0; t < 100; t++) begin
            @(posedge g_clk); #1;
            in_valid = 1; in_shares = {m ^ x, m}; in_shamt = s; in_op = op;
            rng = RW'($urandom);
            set_rdy();
            @(negedge g_clk);
            if (in_ready) begin
                e.rec = ref_op(x, int'(s), op); e.exact = exact; e.sh = in_shares;
                e.b0chk = b0chk; e.b0 = rng[0]; e.lat = lat; e.acc = cyc;
                sb.push_back(e);
                return;
            end
        end
        checks++; errors++;
        $display("FAIL issue_timeout: got no accept expected accept within 100 cycles");
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) begin
            @(posedge g_clk); #1;
            in_valid = 0; rng = RW'($urandom); set_rdy();
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            @(posedge g_clk); #1;
            in_valid = 0; out_ready = 1; rng = RW'($urandom);
            @(negedge g_clk); #1;
            if (sb.size() == 0 && idle) return;
        end
        checks++; errors++;
        $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    endtask

    logic [63:0] prev;
    bit stall = 0;
    always @(negedge g_clk) begin
        if (stall && out_valid) chk("stall_hold", out_shares, prev);
        stall = out_valid && !out_ready;
        prev  = out_shares;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got %h expected none", out_shares);
            end else begin
                me = sb.pop_front();
                chk("result", {32'd0, out_shares[31:0] ^ out_shares[63:32]}, {32'd0, me.rec});
                if (me.exact) chk("shamt0_exact", out_shares, me.sh);
                if (me.b0chk) begin
                    chk("fill_share0", 64'(out_shares[0]), 64'(me.b0));
                    chk("fill_share1", 64'(out_shares[32]), 64'(me.b0));
                end
                if (me.lat) chk("latency", 64'(cyc - me.acc), 64'd5);
            end
        end
    end

    initial begin
        #2 g_resetn = 0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_shares", out_shares, 64'd0);
        repeat (2) @(posedge g_clk);
        @(negedge g_clk) g_resetn = 1;

        issue(32'h8000_0001, 5'd1, 2'd0, 0, 1, 1);
        issue(32'h0000_0001, 5'd1, 2'd2, 0, 0, 1);
        issue(32'h8000_0000, 5'd4, 2'd3, 0, 0, 1);
        issue(32'hFFFF_FFFF, 5'd31, 2'd1, 0, 0, 1);
        for (int op = 0; op < 4; op++) issue($urandom, 5'd0, 2'(op), 1, 0, 1);
        drain();
        chk("idle_after_drain", 64'(idle), 64'd1);

        st_lo = cyc + 7; st_hi = st_lo + 3;
        for (int i = 0; i < 10; i++) issue($urandom, 5'($urandom), 2'($urandom), 0, 0, 0);
        drain();
        st_lo = 0; st_hi = 0;

        rnd_rdy = 1;
        for (int i = 0; i < 40; i++) issue($urandom, 5'($urandom), 2'($urandom), 0, 0, 0);
        rnd_rdy = 0;
        drain();

        for (int i = 0; i < 3; i++) issue($urandom, 5'($urandom), 2'($urandom), 0, 0, 0);
        @(posedge g_clk); #1;
        in_valid = 0; flush = 1; out_ready = 1;
        @(negedge g_clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        @(posedge g_clk); #1;
        flush = 0;
        @(negedge g_clk);
        chk("flush_idle", 64'(idle), 64'd1);
        issue($urandom, 5'($urandom), 2'($urandom), 0, 0, 1);
        drain();

        for (int i = 0; i < 3; i++) issue($urandom, 5'($urandom), 2'($urandom), 0, 0, 0);
        @(posedge g_clk); #1;
        in_valid = 0; g_resetn = 0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_idle", 64'(idle), 64'd1);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_shares", out_shares, 64'd0);
        sb.delete();
        @(negedge g_clk);
        @(posedge g_clk); #1;
        g_resetn = 1;
        idle_cyc(10);
        chk("post_rst_idle", 64'(idle), 64'd1);
        issue($urandom, 5'($urandom), 2'($urandom), 0, 0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
